// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Combinational lookup on the fetch PC, single training port from EX.
module bp_btb #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              next_taken_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       mispred_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ENTRIES-1:0] valid_r;
  logic [1:0]         ctr_r    [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [ADDR_W-1:0]  target_r [ENTRIES];
  logic [31:0]        hit_cnt_r;
  logic [31:0]        mispred_cnt_r;

  logic [IDX_W-1:0]   lk_idx_s;
  logic [TAG_W-1:0]   lk_tag_s;
  logic               lk_hit_s;
  logic [IDX_W-1:0]   up_idx_s;
  logic [TAG_W-1:0]   up_tag_s;
  logic               up_hit_s;
  logic               upd_lsb_unused_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign upd_lsb_unused_s = ^upd_pc_i[1:0];

  // Lookup: table contents seen here are always the pre-update values.
  always_comb begin
    lk_idx_s     = pc_i[IDX_W+1:2];
    lk_tag_s     = pc_i[ADDR_W-1:IDX_W+2];
    lk_hit_s     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    next_pc_o    = pc_i + PC_STEP;
    next_taken_o = 1'b0;
    if (!rst_i && lk_hit_s && ctr_r[lk_idx_s][1]) begin
      next_pc_o    = target_r[lk_idx_s];
      next_taken_o = 1'b1;
    end else begin
      next_pc_o    = pc_i + PC_STEP;
      next_taken_o = 1'b0;
    end
  end

  // Update-side index/tag match.
  always_comb begin
    up_idx_s = upd_pc_i[IDX_W+1:2];
    up_tag_s = upd_pc_i[ADDR_W-1:IDX_W+2];
    up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
  end

  // Valid bits and direction counters; a miss that was not taken leaves the entry alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (upd_valid_i) begin
      if (up_hit_s) begin
        ctr_r[up_idx_s] <= upd_taken_i ? ctr_inc(ctr_r[up_idx_s]) : ctr_dec(ctr_r[up_idx_s]);
      end else if (upd_taken_i) begin
        valid_r[up_idx_s] <= 1'b1;
        ctr_r[up_idx_s]   <= 2'b10;
      end
    end
  end

  // Tag/target payload needs no reset; any taken update (hit or allocate) rewrites it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_valid_i && upd_taken_i) begin
      tag_r[up_idx_s]    <= up_tag_s;
      target_r[up_idx_s] <= upd_target_i;
    end
  end

  // Statistics counters, free-running modulo 2**32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_r     <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      if (lk_hit_s && !stall_i) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (upd_valid_i && upd_mispred_i) begin
        mispred_cnt_r <= mispred_cnt_r + 32'd1;
      end
    end
  end

  assign hit_cnt_o     = hit_cnt_r;
  assign mispred_cnt_o = mispred_cnt_r;

endmodule

// File: tb/tb_bp_btb.sv
// Table-driven bench for bp_btb: one record per cycle, expectations queued
// when a row is driven and compared on the following falling edge.
module tb_bp_btb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        stall_i;
  logic [31:0] next_pc_o;
  logic        next_taken_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispred_i;
  logic [31:0] hit_cnt_o;
  logic [31:0] mispred_cnt_o;

  bp_btb dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .stall_i(stall_i),
    .next_pc_o(next_pc_o), .next_taken_o(next_taken_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_mispred_i(upd_mispred_i),
    .hit_cnt_o(hit_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        e_taken;
    logic [31:0] e_npc;
    logic [31:0] e_hit;
    logic [31:0] e_mis;
  } vec_t;

  typedef struct {
    int          row;
    logic        taken;
    logic [31:0] npc;
    logic [31:0] hit;
    logic [31:0] mis;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, req);
  endtask

  task automatic add(input logic rst, input logic [31:0] pc, input logic stall,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic um,
                     input logic et, input logic [31:0] enpc,
                     input logic [31:0] eh, input logic [31:0] em);
    vec_t v;
    v.rst = rst; v.pc = pc; v.stall = stall; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utgt = utgt; v.um = um; v.e_taken = et; v.e_npc = enpc; v.e_hit = eh; v.e_mis = em;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    //   rst   pc            stl  uv   upc           ut   utgt          um     taken npc           hit    mis
    add(1'b0, 32'h00000100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b0, 32'h00000104, 32'd0,  32'd0); // 0 cold miss
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b1, 32'h00000200, 1'b1,  1'b0, 32'h00000104, 32'd0,  32'd0); // 1 alloc, same-cycle no bypass
    add(1'b0, 32'h00000100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000200, 32'd0,  32'd1); // 2 ctr=10
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b0, 32'h0,        1'b0,  1'b1, 32'h00000200, 32'd1,  32'd1); // 3 NT -> 01
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b0, 32'h0,        1'b0,  1'b0, 32'h00000104, 32'd2,  32'd1); // 4 NT -> 00
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b0, 32'h0,        1'b0,  1'b0, 32'h00000104, 32'd3,  32'd1); // 5 NT stays 00
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b1, 32'h00000200, 1'b0,  1'b0, 32'h00000104, 32'd4,  32'd1); // 6 T -> 01
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b1, 32'h00000200, 1'b0,  1'b0, 32'h00000104, 32'd5,  32'd1); // 7 T -> 10
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b1, 32'h00000200, 1'b0,  1'b1, 32'h00000200, 32'd6,  32'd1); // 8 T -> 11
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b1, 32'h00000200, 1'b0,  1'b1, 32'h00000200, 32'd7,  32'd1); // 9 T stays 11
    add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000100, 1'b0, 32'h0,        1'b0,  1'b1, 32'h00000200, 32'd8,  32'd1); // 10 NT -> 10
    add(1'b0, 32'h00000100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000200, 32'd9,  32'd1); // 11 still taken
    add(1'b0, 32'h00000200, 1'b0, 1'b1, 32'h00000200, 1'b1, 32'h00000300, 1'b1,  1'b0, 32'h00000204, 32'd10, 32'd1); // 12 alias alloc
    add(1'b0, 32'h00000100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b0, 32'h00000104, 32'd10, 32'd2); // 13 old tag evicted
    add(1'b0, 32'h00000200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000300, 32'd10, 32'd2); // 14 new tag hits
    add(1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b0, 32'h00000000, 32'd11, 32'd2); // 15 pc+4 wraps
    add(1'b0, 32'h00000200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000300, 32'd11, 32'd2); // 16 hit counted
    add(1'b0, 32'h00000200, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000300, 32'd12, 32'd2); // 17 stalled hit
    add(1'b0, 32'h00000200, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000300, 32'd12, 32'd2); // 18 stalled hit
    add(1'b0, 32'h00000200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000300, 32'd12, 32'd2); // 19
    add(1'b0, 32'h00000200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000300, 32'd13, 32'd2); // 20
    for (int i = 0; i < 4; i++)                                                                                         // 21-24 mispreds, NT miss
      add(1'b0, 32'h00000100, 1'b0, 1'b1, 32'h00000400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000104, 32'd14, 32'd2 + 32'(i));
    add(1'b0, 32'h00000300, 1'b1, 1'b1, 32'h00000300, 1'b1, 32'h00000500, 1'b0,  1'b0, 32'h00000304, 32'd14, 32'd6);  // 25 update under stall
    add(1'b0, 32'h00000300, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b1, 32'h00000500, 32'd14, 32'd6);  // 26 update not dropped
    add(1'b1, 32'h00000300, 1'b0, 1'b1, 32'h00000600, 1'b1, 32'h00000700, 1'b1,  1'b0, 32'h00000304, 32'd15, 32'd6);  // 27 reset beats update
    add(1'b0, 32'h00000300, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b0, 32'h00000304, 32'd0,  32'd0);  // 28 cleared
    add(1'b0, 32'h00000600, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b0, 32'h00000604, 32'd0,  32'd0);  // 29 update discarded
    add(1'b0, 32'h00000200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,  1'b0, 32'h00000204, 32'd0,  32'd0);  // 30 cleared

    // Reset cycle: lookup must fall through while rst_i is high.
    rst_i = 1'b1; pc_i = 32'h00000100; stall_i = 1'b0;
    upd_valid_i = 1'b0; upd_pc_i = 32'h0; upd_taken_i = 1'b0;
    upd_target_i = 32'h0; upd_mispred_i = 1'b0;
    @(negedge clk_i);
    chk("rst_taken", -1, {31'd0, next_taken_o}, 32'd0);
    chk("rst_npc", -1, next_pc_o, 32'h00000104);
    @(posedge clk_i);

    foreach (vecs[r]) begin
      #1;
      rst_i = vecs[r].rst; pc_i = vecs[r].pc; stall_i = vecs[r].stall;
      upd_valid_i = vecs[r].uv; upd_pc_i = vecs[r].upc; upd_taken_i = vecs[r].ut;
      upd_target_i = vecs[r].utgt; upd_mispred_i = vecs[r].um;
      e.row = r; e.taken = vecs[r].e_taken; e.npc = vecs[r].e_npc;
      e.hit = vecs[r].e_hit; e.mis = vecs[r].e_mis;
      exp_q.push_back(e);
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("next_taken", e.row, {31'd0, next_taken_o}, {31'd0, e.taken});
        chk("next_pc", e.row, next_pc_o, e.npc);
        chk("hit_cnt", e.row, hit_cnt_o, e.hit);
        chk("mispred_cnt", e.row, mispred_cnt_o, e.mis);
      end
      @(posedge clk_i);
    end
    chk("scoreboard_drained", -1, 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_btb.md
Name: bp_btb

Overview:
- Branch predictor that sits directly upstream of the fetch-PC stage and produces its next_pc/next_taken inputs.
- Direct-mapped branch target buffer (BTB); each entry carries a 2-bit saturating direction counter.
- Lookup is combinational on the current fetch PC.
- Training comes from the EX-stage branch resolution one or more cycles later.
- Prediction is forwarded through fetch to EX, where it is checked for redirect.

Parameters:
- ADDR_W, 32, instruction address width.
- IDX_W, 6, BTB index width; entries = 2**IDX_W = 64.
- TAG_W, ADDR_W-IDX_W-2 = 24, stored tag width, taken from pc[ADDR_W-1:IDX_W+2].

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- pc_i  in  ADDR_W  current fetch PC (fetch stage pc_o).
- stall_i  in  1  fetch stalled; freezes the hit counter only.
- next_pc_o  out  ADDR_W  predicted next fetch PC.
- next_taken_o  out  1  1 = predicted taken via BTB target.
- upd_valid_i  in  1  EX resolved a branch/jump this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolved instruction.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_mispred_i  in  1  EX detected a misprediction (redirect asserted).
- hit_cnt_o  out  32  number of non-stalled cycles with a BTB hit.
- mispred_cnt_o  out  32  number of mispredictions reported.

Behaviour:
- Reset (synchronous, rst_i=1 at a rising edge), applied to all 64 entries:
  - valid=0, counter=2'b01 (weakly not-taken).
  - tag and target are don't-care.
  - hit_cnt_o=0, mispred_cnt_o=0.
- While rst_i=1, next_taken_o=0 and next_pc_o=pc_i+4.
- Reset asserted mid-training discards any update in that cycle.
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==tag(pc_i).
  - If hit && counter[1]: next_taken_o=1, next_pc_o=target[idx].
  - Otherwise: next_taken_o=0, next_pc_o=pc_i+4.
  - pc_i+4 is modulo 2**ADDR_W; 0xFFFFFFFC wraps to 0x00000000.
- Update, at the edge when upd_valid_i=1, using idx/tag of upd_pc_i:
  - Entry hit, taken: counter saturating increment (11 stays 11); target <= upd_target_i.
  - Entry hit, not taken: counter saturating decrement (00 stays 00); target unchanged; entry stays valid.
  - Entry miss, taken: allocate and overwrite any aliasing entry: valid=1, tag, target=upd_target_i, counter=2'b10 (weakly taken).
  - Entry miss, not taken: no state change.
- Same-cycle lookup and update to the same idx:
  - The lookup sees pre-update contents.
  - The new contents are visible from the next cycle (no bypass).
- Counters:
  - hit_cnt_o increments when hit && !stall_i && !rst_i.
  - mispred_cnt_o increments when upd_valid_i && upd_mispred_i && !rst_i.
  - Both wrap at 2**32 (0xFFFFFFFF -> 0).
- stall_i has no effect on table updates; a pending EX update is never dropped.
- Only a single update port exists; no write-port conflict.
- Storage is a register array; the implementation must not add a read cycle.

Test Plan:
- Reset then lookup pc_i=0x00000100 -> next_taken_o=0, next_pc_o=0x00000104, hit_cnt_o=0.
- Update pc=0x00000100, taken=1, target=0x00000200; next cycle lookup pc_i=0x00000100 -> next_taken_o=1, next_pc_o=0x00000200 (counter=10).
- Same entry: two not-taken updates -> counter 10->01->00, lookup gives next_taken_o=0, next_pc_o=0x00000104. Then three taken updates -> counter 11; a fourth taken keeps 11, and one not-taken update still predicts taken.
- Alias test: allocate pc=0x00000100 (target 0x200), then taken update pc=0x00000200 (same idx 0, different tag, target 0x300). Lookup 0x100 -> miss, next_pc_o=0x104; lookup 0x200 -> next_pc_o=0x300.
- Same-cycle: lookup pc_i=0x00000100 while allocating it -> that cycle next_taken_o=0; following cycle next_taken_o=1. pc_i=0xFFFFFFFC on a miss -> next_pc_o=0x00000000.
- Counters: 5 cycles of hit with stall_i high for 2 of them -> hit_cnt_o=3. 4 updates with upd_mispred_i=1 -> mispred_cnt_o=4. rst_i pulse -> both 0 and all lookups miss.
